// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle control FSM and the RV32I datapath.
// Memory handshake: mem_req is valid and mem_ready is ready. Once mem_req is
// raised, mem_req, mem_write and adr_src stay stable until the cycle where
// mem_ready is high. That cycle completes the transfer.
interface multicycle_control_fsm_if #(
  parameter int CNT_WIDTH = 32
);
  logic [6:0]           opcode;
  logic                 branch_taken;
  logic                 mem_ready;
  logic                 mem_req;
  logic                 mem_write;
  logic                 adr_src;
  logic                 ir_write;
  logic                 pc_write;
  logic                 reg_write;
  logic [1:0]           alu_src_a;
  logic [1:0]           alu_src_b;
  logic [1:0]           result_src;
  logic                 force_add;
  logic                 illegal_instr;
  logic [3:0]           state;
  logic [CNT_WIDTH-1:0] instr_retired;

  // Controller side
  modport master (
    input  opcode, branch_taken, mem_ready,
    output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, result_src, force_add, illegal_instr,
           state, instr_retired
  );

  // Datapath / memory side
  modport slave (
    output opcode, branch_taken, mem_ready,
    input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, result_src, force_add, illegal_instr,
           state, instr_retired
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multicycle RV32I core: sequences fetch, decode,
// execute, memory and writeback, and counts retired instructions.
module multicycle_control_fsm #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  multicycle_control_fsm_if.master  bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JUMP     = 4'd10,
    JALR     = 4'd11,
    LUI      = 4'd12,
    TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_J     = 7'b1101111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] retired_q;

  logic       mem_req, mem_write, adr_src, ir_write, reg_write, force_add;
  logic       pc_update, branch, retire;
  logic [1:0] alu_src_a, alu_src_b, result_src;

  // State register; reset always returns to FETCH, even mid memory request
  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Retired-instruction counter; wraps naturally at 2^CNT_WIDTH
  always_ff @(posedge clk) begin
    if (reset)       retired_q <= '0;
    else if (retire) retired_q <= retired_q + 1'b1;
  end

  // Next-state and control decode; unlisted controls default to 0
  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    force_add  = 1'b0;
    pc_update  = 1'b0;
    branch     = 1'b0;
    retire     = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    case (state_q)
      FETCH: begin
        // PC <= PC+4 on the live ALU result in the same cycle IR loads
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        force_add  = 1'b1;
        ir_write   = bus.mem_ready;
        pc_update  = bus.mem_ready;
        if (bus.mem_ready) state_d = DECODE;
      end
      DECODE: begin
        // Precompute OldPC+imm: branch target, jal target and auipc result
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        force_add = 1'b1;
        case (bus.opcode)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_R:              state_d = EXECR;
          OP_I:              state_d = EXECI;
          OP_B:              state_d = BRANCH;
          OP_J:              state_d = JUMP;
          OP_JALR:           state_d = JALR;
          OP_LUI:            state_d = LUI;
          OP_AUIPC:          state_d = ALUWB;
          default:           state_d = TRAP;
        endcase
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        force_add = 1'b1;
        state_d   = (bus.opcode == OP_STORE) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (bus.mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_d    = FETCH;
      end
      MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (bus.mem_ready) begin
          retire  = 1'b1;
          state_d = FETCH;
        end
      end
      EXECR: begin
        alu_src_a = 2'b10;
        state_d   = ALUWB;
      end
      EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = ALUWB;
      end
      LUI: begin
        // zero + imm through the adder
        alu_src_a = 2'b11;
        alu_src_b = 2'b01;
        force_add = 1'b1;
        state_d   = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = FETCH;
      end
      BRANCH: begin
        // ALU compares rs1/rs2 while ALUOut still holds the target
        alu_src_a = 2'b10;
        branch    = 1'b1;
        retire    = 1'b1;
        state_d   = FETCH;
      end
      JALR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        force_add = 1'b1;
        state_d   = JUMP;
      end
      JUMP: begin
        // PC <= ALUOut (target) while the ALU forms OldPC+4 for rd
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        force_add = 1'b1;
        pc_update = 1'b1;
        state_d   = ALUWB;
      end
      TRAP:    state_d = TRAP;
      default: state_d = TRAP;
    endcase
  end

  // Output drive; everything reads as zero while reset is held
  assign bus.mem_req       = !reset && mem_req;
  assign bus.mem_write     = !reset && mem_write;
  assign bus.adr_src       = !reset && adr_src;
  assign bus.ir_write      = !reset && ir_write;
  assign bus.pc_write      = !reset && (pc_update || (branch && bus.branch_taken));
  assign bus.reg_write     = !reset && reg_write;
  assign bus.force_add     = !reset && force_add;
  assign bus.alu_src_a     = reset ? 2'b00 : alu_src_a;
  assign bus.alu_src_b     = reset ? 2'b00 : alu_src_b;
  assign bus.result_src    = reset ? 2'b00 : result_src;
  assign bus.illegal_instr = !reset && (state_q == TRAP);
  assign bus.state         = reset ? 4'd0 : state_q;
  assign bus.instr_retired = reset ? '0 : retired_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: walks every instruction class
// through its state path and checks strobes, waits, trap and the counter.
module tb_multicycle_control_fsm;

  logic clk = 1'b0;
  logic reset;

  multicycle_control_fsm_if #(.CNT_WIDTH(32)) bus ();

  multicycle_control_fsm #(.CNT_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int          n_checks = 0;
  int          n_errors = 0;
  logic [3:0]  exp_q[$];
  logic [31:0] exp_ret = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle and settle away from the edge
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Start in FETCH, then follow the states queued in exp_q (mem_ready high)
  task automatic run_path(input logic [6:0] op, input logic bt);
    logic [3:0] st;
    bus.opcode       = op;
    bus.branch_taken = bt;
    bus.mem_ready    = 1'b1;
    #1;
    check("start_state", bus.state, 4'd0);
    check("start_ir_write", bus.ir_write, 1'b1);
    while (exp_q.size() > 0) begin
      st = exp_q.pop_front();
      step();
      check("path_state", bus.state, st);
      check("path_reg_write", bus.reg_write, (st == 4'd8 || st == 4'd4));
      check("path_pc_write", bus.pc_write,
            (st == 4'd0 || st == 4'd10 || (st == 4'd9 && bt)));
      check("path_mem_req", bus.mem_req, (st == 4'd0 || st == 4'd3 || st == 4'd5));
    end
  endtask

  task automatic check_retired();
    check("instr_retired", bus.instr_retired, exp_ret);
  endtask

  initial begin
    reset            = 1'b1;
    bus.opcode       = 7'd0;
    bus.branch_taken = 1'b0;
    bus.mem_ready    = 1'b1;
    step();
    step();
    check("rst_state", bus.state, 4'd0);
    check("rst_mem_req", bus.mem_req, 1'b0);
    check("rst_pc_write", bus.pc_write, 1'b0);
    check("rst_retired", bus.instr_retired, 32'd0);

    // Release reset: FETCH with mem_ready high
    reset = 1'b0;
    #1;
    check("rel_state", bus.state, 4'd0);
    check("rel_mem_req", bus.mem_req, 1'b1);
    check("rel_ir_write", bus.ir_write, 1'b1);
    check("rel_pc_write", bus.pc_write, 1'b1);
    check("rel_force_add", bus.force_add, 1'b1);
    check("rel_result_src", bus.result_src, 2'b10);
    check("rel_retired", bus.instr_retired, 32'd0);

    // FETCH holds with no strobes while memory is not ready
    bus.mem_ready = 1'b0;
    #1;
    check("fwait_ir_write", bus.ir_write, 1'b0);
    check("fwait_pc_write", bus.pc_write, 1'b0);
    step();
    check("fwait_state", bus.state, 4'd0);
    check("fwait_mem_req", bus.mem_req, 1'b1);

    // R-type
    exp_q = '{4'd1, 4'd6, 4'd8, 4'd0};
    run_path(7'b0110011, 1'b0);
    exp_ret++; check_retired();

    // Load with three wait cycles in MEMREAD
    bus.opcode    = 7'b0000011;
    bus.mem_ready = 1'b1;
    step();
    check("ld_decode", bus.state, 4'd1);
    check("ld_dec_srca", bus.alu_src_a, 2'b01);
    check("ld_dec_srcb", bus.alu_src_b, 2'b01);
    step();
    check("ld_memadr", bus.state, 4'd2);
    check("ld_adr_srca", bus.alu_src_a, 2'b10);
    check("ld_adr_force", bus.force_add, 1'b1);
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 3) bus.mem_ready = 1'b1;
      #1;
      check("ld_memread", bus.state, 4'd3);
      check("ld_mr_mem_req", bus.mem_req, 1'b1);
      check("ld_mr_adr_src", bus.adr_src, 1'b1);
      check("ld_mr_reg_write", bus.reg_write, 1'b0);
    end
    step();
    check("ld_memwb", bus.state, 4'd4);
    check("ld_wb_reg_write", bus.reg_write, 1'b1);
    check("ld_wb_result_src", bus.result_src, 2'b01);
    step();
    check("ld_back", bus.state, 4'd0);
    exp_ret++; check_retired();

    // Branch not taken, then taken
    exp_q = '{4'd1, 4'd9, 4'd0};
    run_path(7'b1100011, 1'b0);
    exp_ret++; check_retired();
    exp_q = '{4'd1, 4'd9, 4'd0};
    run_path(7'b1100011, 1'b1);
    exp_ret++; check_retired();

    // jalr, jal, I-logic, lui, auipc
    exp_q = '{4'd1, 4'd11, 4'd10, 4'd8, 4'd0};
    run_path(7'b1100111, 1'b0);
    exp_ret++; check_retired();
    exp_q = '{4'd1, 4'd10, 4'd8, 4'd0};
    run_path(7'b1101111, 1'b0);
    exp_ret++; check_retired();
    exp_q = '{4'd1, 4'd7, 4'd8, 4'd0};
    run_path(7'b0010011, 1'b0);
    exp_ret++; check_retired();
    bus.opcode = 7'b0110111;
    step(); step();
    check("lui_state", bus.state, 4'd12);
    check("lui_srca", bus.alu_src_a, 2'b11);
    check("lui_force", bus.force_add, 1'b1);
    step(); step();
    check("lui_back", bus.state, 4'd0);
    exp_ret++; check_retired();
    exp_q = '{4'd1, 4'd8, 4'd0};
    run_path(7'b0010111, 1'b0);
    exp_ret++; check_retired();

    // Store with one wait cycle in MEMWRITE
    bus.opcode = 7'b0100011;
    step(); step();
    check("st_memadr", bus.state, 4'd2);
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      if (i == 1) bus.mem_ready = 1'b1;
      #1;
      check("st_memwrite", bus.state, 4'd5);
      check("st_mem_write", bus.mem_write, 1'b1);
      check("st_adr_src", bus.adr_src, 1'b1);
      check("st_reg_write", bus.reg_write, 1'b0);
    end
    step();
    check("st_back", bus.state, 4'd0);
    exp_ret++; check_retired();

    // Illegal opcode traps until reset
    exp_q = '{4'd1, 4'd15};
    run_path(7'b1111111, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step();
      check("trap_state", bus.state, 4'd15);
      check("trap_illegal", bus.illegal_instr, 1'b1);
      check("trap_strobes",
            {bus.mem_req, bus.mem_write, bus.ir_write, bus.pc_write, bus.reg_write}, 5'd0);
    end
    check_retired();
    reset = 1'b1;
    #1;
    check("trap_rst_illegal", bus.illegal_instr, 1'b0);
    step();
    reset = 1'b0;
    #1;
    check("trap_rel_state", bus.state, 4'd0);
    check("trap_rel_illegal", bus.illegal_instr, 1'b0);
    check("trap_rel_retired", bus.instr_retired, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Main control state machine for the multicycle RV32I core.
- Sequences the shared single-port memory, the instruction register, the PC, the register file and the ALU through fetch, decode, execute, memory and writeback steps.
- Consumes the opcode from the instruction decode stage, the branch comparison result and the memory handshake.
- Drives all datapath mux selects and write strobes, plus a retired-instruction counter.

Parameters:
CNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
clk  in  1  system clock; all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
opcode  in  7  instr[6:0] from instruction decode; RType 0110011, IType_logic 0010011, IType_load 0000011, IType_jalr 1100111, SType 0100011, BType 1100011, JType 1101111, UType_auipc 0010111, UType_lui 0110111.
branch_taken  in  1  ALU branch comparison true.
mem_ready  in  1  memory completes the current request this cycle.
mem_req  out  1  memory request valid.
mem_write  out  1  request is a store.
adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut.
ir_write  out  1  load IR and OldPC.
pc_write  out  1  PC load enable.
reg_write  out  1  register file write strobe.
alu_src_a  out  2  ALU operand A select: 00 = PC, 01 = OldPC, 10 = rs1 data, 11 = zero.
alu_src_b  out  2  ALU operand B select: 00 = rs2 data, 01 = imm_ext, 10 = constant 4.
result_src  out  2  result bus select: 00 = ALUOut, 01 = memory data register, 10 = live ALU result.
force_add  out  1  datapath overrides ALUControl with ADD.
illegal_instr  out  1  sticky illegal-opcode flag.
state  out  4  current state encoding, for debug.
instr_retired  out  CNT_WIDTH  count of completed instructions.

Behaviour:
- States and encodings:
  - 0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMREAD, 4 MEMWB, 5 MEMWRITE, 6 EXECR, 7 EXECI, 8 ALUWB, 9 BRANCH, 10 JUMP, 11 JALR, 12 LUI, 15 TRAP.
  - Codes 13 and 14 are unused; if reached, go to TRAP.
- Reset:
  - While reset is high, every output is 0, instr_retired is 0 and illegal_instr is cleared.
  - The next state is FETCH. This applies in any state, including mid memory request.
- Output rules:
  - All outputs not listed for a state are 0.
  - pc_write = pc_update OR (branch AND branch_taken). pc_update and branch are internal signals.
- FETCH:
  - mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, result_src=10, force_add=1.
  - ir_write and pc_update = mem_ready (Mealy).
  - Hold while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE:
  - alu_src_a=01, alu_src_b=01, force_add=1, so ALUOut <= OldPC+imm.
  - Next state by opcode: load/store -> MEMADR, RType -> EXECR, IType_logic -> EXECI, BType -> BRANCH, JType -> JUMP, IType_jalr -> JALR, UType_lui -> LUI, UType_auipc -> ALUWB (reuses OldPC+imm), any other -> TRAP.
- MEMADR: alu_src_a=10, alu_src_b=01, force_add=1. Load -> MEMREAD, store -> MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1. Hold until mem_ready, then go to MEMWB.
- MEMWB: result_src=01, reg_write=1 -> FETCH (retires).
- MEMWRITE:
  - mem_req=1, mem_write=1, adr_src=1, held stable while waiting.
  - On mem_ready go to FETCH (retires).
- EXECR: alu_src_a=10, alu_src_b=00 -> ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01 -> ALUWB.
- LUI: alu_src_a=11, alu_src_b=01, force_add=1 -> ALUWB.
- ALUWB: result_src=00, reg_write=1 -> FETCH (retires).
- BRANCH:
  - alu_src_a=10, alu_src_b=00, result_src=00, branch=1.
  - pc_write = branch_taken, loading the target from ALUOut.
  - Go to FETCH (retires).
- JALR: alu_src_a=10, alu_src_b=01, force_add=1, so ALUOut <= rs1+imm. Go to JUMP.
- JUMP:
  - alu_src_a=01, alu_src_b=10, force_add=1, result_src=00, pc_update=1.
  - PC <= ALUOut (the target), while the ALU computes OldPC+4. Go to ALUWB.
  - The datapath clears bit 0 of the JALR target.
- TRAP:
  - illegal_instr=1, all strobes 0.
  - Remains in TRAP until reset.
- instr_retired:
  - Increments by 1 on each transition into FETCH from MEMWB, ALUWB, BRANCH or MEMWRITE.
  - Wraps modulo 2^CNT_WIDTH. Never increments during reset.
- Cycle counts, assuming mem_ready is high on the first cycle:
  - R/I-logic, lui, auipc: 4 cycles (auipc 3).
  - Load: 5. Store: 4. Branch: 3. jal: 4. jalr: 5.
- Each memory wait cycle adds 1 cycle.

Test Plan:
- Reset held 2 cycles, then released with mem_ready=1 -> state=0, mem_req=1, ir_write=1, pc_write=1, instr_retired=0.
- opcode=0110011, mem_ready=1 -> states 0,1,6,8,0; reg_write=1 only in state 8; instr_retired increments 0 -> 1.
- opcode=0000011, mem_ready low for 3 cycles in MEMREAD -> state 3 held 4 cycles with mem_req=1, adr_src=1; then state 4 with reg_write=1, result_src=01.
- opcode=1100011, branch_taken=0 and then a second run with branch_taken=1 -> pc_write in BRANCH is 0 and 1 respectively; both return to FETCH.
- opcode=1100111 -> states 0,1,11,10,8,0; pc_write=1 in state 10; reg_write=1 in state 8.
- opcode=1111111 -> TRAP (state=15), illegal_instr=1, no strobes for 10 cycles; reset -> FETCH, illegal_instr=0.
